// File: rtl/multibyte_add_sequencer.sv
// Byte-serial N-byte add/subtract: one 8-bit ripple adder reused across BYTES
// cycles, least-significant byte first, with valid/ready request and result ports.
module multibyte_add_sequencer #(
   parameter int unsigned BYTES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*BYTES-1:0]   A,
   input  logic [8*BYTES-1:0]   B,
   input  logic                 Cin,
   input  logic                 op_sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*BYTES-1:0]   Sum,
   output logic                 Cout,
   output logic                 Ovf,
   output logic                 busy
);

   localparam int unsigned W  = 8 * BYTES;
   localparam int unsigned IW = $clog2(BYTES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   sum_q;
   logic [W-1:0]   sum_nx;
   logic           carry_q;
   logic [IW-1:0]  idx;
   logic [7:0]     a_byte;
   logic [7:0]     b_byte;
   logic [7:0]     add_sum;
   logic           add_cout;
   logic           last;

   // Shared 8-bit ripple adder on the currently selected byte lane
   always_comb begin
      a_byte              = a_q[8*idx +: 8];
      b_byte              = b_q[8*idx +: 8];
      {add_cout, add_sum} = 9'(a_byte) + 9'(b_byte) + 9'(carry_q);
      last                = (idx == IW'(BYTES - 1));
      sum_nx              = sum_q;
      sum_nx[8*idx +: 8]  = add_sum;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and handshake decode; flags depend on state only
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture, byte accumulation and result registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx     <= '0;
         Sum     <= '0;
         Cout    <= 1'b0;
         Ovf     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= A;
                  b_q     <= op_sub ? ~B : B;
                  carry_q <= op_sub ? 1'b1 : Cin;
                  idx     <= '0;
               end
            end
            RUN: begin
               sum_q   <= sum_nx;
               carry_q <= add_cout;
               idx     <= idx + IW'(1);
               if (last) begin
                  Sum  <= sum_nx;
                  Cout <= add_cout;
                  // Signed overflow: operands agree in sign, result does not
                  Ovf  <= (a_q[W-1] == b_q[W-1]) && (add_sum[7] != a_q[W-1]);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Scoreboard bench for multibyte_add_sequencer: directed vectors push expected
// results; a monitor pops and compares on every result handshake.
module tb_multibyte_add_sequencer;

   localparam int unsigned BYTES = 4;
   localparam int unsigned W     = 8 * BYTES;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          Cin;
   logic          op_sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  Sum;
   logic          Cout;
   logic          Ovf;
   logic          busy;

   res_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   multibyte_add_sequencer #(.BYTES(BYTES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Sum       (Sum),
      .Cout      (Cout),
      .Ovf       (Ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] s, input logic c, input logic o);
      res_t r;
      r.sum  = s;
      r.cout = c;
      r.ovf  = o;
      exp_q.push_back(r);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (!in_ready) check("in_ready_timeout", W'(in_ready), W'(1));
   endtask

   task automatic wait_out_valid();
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      if (!out_valid) check("out_valid_timeout", W'(out_valid), W'(1));
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
      wait_ready();
      A        = a;
      B        = b;
      Cin      = cin;
      op_sub   = sub;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Issue one request with out_ready high and wait for its result to be taken
   task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W-1:0] s, input logic c, input logic o);
      push(s, c, o);
      send(a, b, cin, sub);
      wait_out_valid();
      tick();
   endtask

   // Monitor: compare whenever a result is handed over
   initial begin : monitor
      res_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_result: got Sum=%h Cout=%b Ovf=%b with nothing outstanding",
                        Sum, Cout, Ovf);
            end else begin
               e = exp_q.pop_front();
               check("sum",  Sum,       e.sum);
               check("cout", W'(Cout),  W'(e.cout));
               check("ovf",  W'(Ovf),   W'(e.ovf));
            end
         end
      end
   end

   initial begin : stim
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      A         = '0;
      B         = '0;
      Cin       = 1'b0;
      op_sub    = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_in_ready",  W'(in_ready),  W'(1));
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_busy",      W'(busy),      W'(0));
      check("rst_sum",       Sum,           32'h0);
      check("rst_cout",      W'(Cout),      W'(0));
      check("rst_ovf",       W'(Ovf),       W'(0));

      // Carry chain across byte 0->1, with latency and busy window
      push(32'h0000_0100, 1'b0, 1'b0);
      send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("lat_busy",      W'(busy),      W'(1));
         check("lat_out_valid", W'(out_valid), W'(0));
         check("lat_in_ready",  W'(in_ready),  W'(0));
         tick();
      end
      check("lat_out_valid_rise", W'(out_valid), W'(1));
      check("lat_busy_fall",      W'(busy),      W'(0));
      tick();
      check("lat_back_idle", W'(in_ready), W'(1));

      run_vec(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      run_vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      run_vec(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      run_vec(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);

      // Reset two cycles into RUN: aborted request yields no result
      send(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_out_valid", W'(out_valid), W'(0));
      check("abort_busy",      W'(busy),      W'(0));
      check("abort_in_ready",  W'(in_ready),  W'(1));
      check("abort_sum",       Sum,           32'h0);
      check("abort_cout",      W'(Cout),      W'(0));
      check("abort_ovf",       W'(Ovf),       W'(0));
      for (int i = 0; i < 8; i++) begin
         check("abort_no_result", W'(out_valid), W'(0));
         tick();
      end

      // Back-pressure: result held, new requests refused
      out_ready = 1'b0;
      push(32'h2345_6789, 1'b0, 1'b0);
      send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      wait_out_valid();
      for (int i = 0; i < 6; i++) begin
         A        = 32'h0000_0001;
         B        = 32'h0000_0001;
         op_sub   = 1'b0;
         in_valid = 1'b1;
         check("bp_in_ready",  W'(in_ready),  W'(0));
         check("bp_out_valid", W'(out_valid), W'(1));
         check("bp_sum",       Sum,           32'h2345_6789);
         check("bp_cout",      W'(Cout),      W'(0));
         check("bp_ovf",       W'(Ovf),       W'(0));
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release_out_valid", W'(out_valid), W'(0));
      check("bp_release_in_ready",  W'(in_ready),  W'(1));
      run_vec(32'h0001_0000, 32'hFFFF_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

      for (int i = 0; i < 10; i++) tick();
      check("scoreboard_drained", W'(exp_q.size()), W'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
